frame_capture_buffer: RTL and testbench

FRAME_CAPTURE_BUFFER -- requirements
Module: frame_capture_buffer

---
 rtl/frame_capture_buffer_if.sv | 29 ++
 rtl/frame_capture_buffer.sv | 185 ++++++++++++++++++
 tb/tb_frame_capture_buffer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_buffer_if.sv
// BRAM port bundle for frame_capture_buffer: the capture block drives address/data/enable
// and receives read data one cycle after issuing an address.
`default_nettype none

interface frame_capture_buffer_if #(
  parameter int ADDR_W   = 19,
  parameter int PIX_BITS = 8
);
  logic [ADDR_W-1:0]   bram_addr;
  logic [PIX_BITS-1:0] bram_din;
  logic                bram_we;
  logic [PIX_BITS-1:0] bram_dout;

  modport master (
    output bram_addr,
    output bram_din,
    output bram_we,
    input  bram_dout
  );

  modport slave (
    input  bram_addr,
    input  bram_din,
    input  bram_we,
    output bram_dout
  );
endinterface

`default_nettype wire

// File: rtl/frame_capture_buffer.sv
// Captures one or more raster frames into an external single-port BRAM and replays the most
// recently completed frame in lock-step with the live raster.
`default_nettype none

module frame_capture_buffer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 400,
  parameter int PIX_BITS  = 8,
  parameter int NUM_SLOTS = 2
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  input  wire logic                 capture_sw,
  input  wire logic                 continuous,
  input  wire logic [10:0]          hcount,
  input  wire logic [9:0]           vcount,
  input  wire logic [23:0]          pixel_in,
  frame_capture_buffer_if.master    bram,
  output logic      [PIX_BITS-1:0]  pixel_out,
  output logic                      pixel_valid,
  output logic                      in_display,
  output logic                      frame_ready,
  output logic                      busy
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W    = $clog2(FRAME_PIX * NUM_SLOTS);
  localparam int PTR_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(FRAME_PIX - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [ADDR_W-1:0] FRAME_PIX_A = ADDR_W'(FRAME_PIX);
  localparam logic [10:0]       H_LIM       = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM       = 10'(V_ACTIVE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_WRITING = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  if (!(PIX_BITS == 8 || PIX_BITS == 16 || PIX_BITS == 24)) begin : g_bad_pix_bits
    $error("frame_capture_buffer: PIX_BITS must be 8, 16 or 24");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 4) begin : g_bad_num_slots
    $error("frame_capture_buffer: NUM_SLOTS must be in 1..4");
  end
  if (H_ACTIVE < 1 || H_ACTIVE > 2047 || V_ACTIVE < 1 || V_ACTIVE > 1023 || FRAME_PIX < 2) begin : g_bad_geometry
    $error("frame_capture_buffer: H_ACTIVE/V_ACTIVE out of range for the raster counters");
  end

  logic [1:0]        state_q, state_d;
  logic              cap_q;
  logic              live_q;
  logic              cont_q, cont_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
  logic              frame_ready_q, frame_ready_d;
  logic              pix_valid_q;

  logic                cap_rise;
  logic                cap_fall;
  logic                start;
  logic                wr_en;
  logic                rd_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [PIX_BITS-1:0] packed_pix;
  logic                unused_pix;

  assign unused_pix = ^pixel_in;

  if (PIX_BITS == 8) begin : g_pack_rgb332
    assign packed_pix = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]};
  end else if (PIX_BITS == 16) begin : g_pack_rgb565
    assign packed_pix = {pixel_in[23:19], pixel_in[15:10], pixel_in[7:3]};
  end else begin : g_pack_rgb888
    assign packed_pix = PIX_BITS'(pixel_in);
  end

  // live_q holds off the first rise until the second clock after reset release.
  assign cap_rise   = capture_sw & ~cap_q & live_q;
  assign cap_fall   = ~capture_sw & cap_q;
  assign in_display = (hcount < H_LIM) && (vcount < V_LIM);
  assign start      = (state_q == ST_ARMED) && (hcount == 11'd0) && (vcount == 10'd0);
  assign wr_en      = ((state_q == ST_WRITING) || start) && in_display;
  assign rd_en      = !wr_en && frame_ready_q && in_display;
  assign wr_addr    = ADDR_W'(wr_slot_q) * FRAME_PIX_A + ADDR_W'(wr_ptr_q);
  assign rd_addr    = ADDR_W'(rd_slot_q) * FRAME_PIX_A + ADDR_W'(rd_ptr_q);

  assign bram.bram_we   = wr_en;
  assign bram.bram_din  = wr_en ? packed_pix : '0;
  assign bram.bram_addr = wr_en ? wr_addr : (rd_en ? rd_addr : '0);
  assign pixel_out      = pix_valid_q ? bram.bram_dout : '0;
  assign pixel_valid    = pix_valid_q;
  assign frame_ready    = frame_ready_q;
  assign busy           = (state_q == ST_ARMED) || (state_q == ST_WRITING);

  always_comb begin
    state_d       = state_q;
    cont_d        = cont_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_slot_d     = wr_slot_q;
    rd_slot_d     = rd_slot_q;
    frame_ready_d = frame_ready_q;
    // A release outranks everything, including a frame completing this cycle.
    if (cap_fall) begin
      state_d       = ST_IDLE;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      wr_slot_d     = '0;
      rd_slot_d     = '0;
      frame_ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          wr_slot_d     = '0;
          rd_slot_d     = '0;
          frame_ready_d = 1'b0;
          if (cap_rise) begin
            state_d = ST_ARMED;
            cont_d  = continuous;
          end
        end
        ST_ARMED: begin
          if (start) state_d = ST_WRITING;
        end
        default: begin
        end
      endcase
      if (wr_en) begin
        if (wr_ptr_q == PTR_LAST) begin
          wr_ptr_d      = '0;
          frame_ready_d = 1'b1;
          rd_slot_d     = wr_slot_q;
          rd_ptr_d      = '0;
          if (cont_q) begin
            wr_slot_d = (wr_slot_q == SLOT_LAST) ? '0 : wr_slot_q + 1'b1;
            state_d   = ST_ARMED;
          end else begin
            state_d   = ST_READING;
          end
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end else if (rd_en) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cap_q         <= 1'b0;
      live_q        <= 1'b0;
      cont_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_slot_q     <= '0;
      rd_slot_q     <= '0;
      frame_ready_q <= 1'b0;
      pix_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_q         <= capture_sw;
      live_q        <= 1'b1;
      cont_q        <= cont_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_slot_q     <= wr_slot_d;
      rd_slot_q     <= rd_slot_d;
      frame_ready_q <= frame_ready_d;
      pix_valid_q   <= rd_en;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_capture_buffer.sv
// Scoreboard bench for frame_capture_buffer on an 8x4 active raster (10x6 total), two slots.
`default_nettype none

module tb_frame_capture_buffer;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int FP    = H * V;
  localparam int AW    = 6;
  localparam int H_TOT = 10;
  localparam int V_TOT = 6;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        capture_sw;
  logic        continuous;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [23:0] pixel_in;

  always #5 clock = ~clock;

  frame_capture_buffer_if #(.ADDR_W(AW), .PIX_BITS(24)) bus   ();
  frame_capture_buffer_if #(.ADDR_W(AW), .PIX_BITS(8))  bus8  ();
  frame_capture_buffer_if #(.ADDR_W(AW), .PIX_BITS(16)) bus16 ();

  logic [23:0] pixel_out;
  logic        pixel_valid, in_display, frame_ready, busy;
  logic [7:0]  po8;
  logic [15:0] po16;
  logic        pv8, id8, fr8, bz8, pv16, id16, fr16, bz16;

  frame_capture_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_BITS(24), .NUM_SLOTS(2)) dut (
    .clock(clock), .reset_n(reset_n), .capture_sw(capture_sw), .continuous(continuous),
    .hcount(hcount), .vcount(vcount), .pixel_in(pixel_in), .bram(bus),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .in_display(in_display),
    .frame_ready(frame_ready), .busy(busy));

  frame_capture_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_BITS(8), .NUM_SLOTS(2)) dut8 (
    .clock(clock), .reset_n(reset_n), .capture_sw(capture_sw), .continuous(continuous),
    .hcount(hcount), .vcount(vcount), .pixel_in(pixel_in), .bram(bus8),
    .pixel_out(po8), .pixel_valid(pv8), .in_display(id8), .frame_ready(fr8), .busy(bz8));

  frame_capture_buffer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_BITS(16), .NUM_SLOTS(2)) dut16 (
    .clock(clock), .reset_n(reset_n), .capture_sw(capture_sw), .continuous(continuous),
    .hcount(hcount), .vcount(vcount), .pixel_in(pixel_in), .bram(bus16),
    .pixel_out(po16), .pixel_valid(pv16), .in_display(id16), .frame_ready(fr16), .busy(bz16));

  assign bus8.bram_dout  = '0;
  assign bus16.bram_dout = '0;

  logic [23:0] mem [0:63];
  always @(posedge clock) begin
    if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= mem[bus.bram_addr];
  end

  typedef struct packed {
    logic [5:0]  a;
    logic [23:0] d;
  } wr_t;

  wr_t         exp_wr [$];
  logic [23:0] exp_rd [$];
  logic [23:0] shadow [0:63];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          rd_ptr = 0;

  // Two packing vectors: {R[7:5],G[7:5],B[7:6]} and {R[7:3],G[7:2],B[7:3]} worked by hand.
  logic [23:0] pk_in  [0:1];
  logic [7:0]  pk8    [0:1];
  logic [15:0] pk16   [0:1];
  initial begin
    pk_in[0] = 24'hFF8040; pk8[0] = 8'hF1; pk16[0] = 16'hFC08;
    pk_in[1] = 24'h1FE3C0; pk8[1] = 8'h1F; pk16[1] = 16'h1F18;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int h, input int v);
    if (f == 0 && v == 0 && h < 2) return pk_in[h];
    return {8'(f), 8'(v * 16 + h), 8'(8'hC3 ^ 8'(h * 8 + v))};
  endfunction

  always @(negedge clock) begin
    wr_t e;
    logic [23:0] r;
    if (bus.bram_we) begin
      if (exp_wr.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", bus.bram_addr, bus.bram_din);
      end else begin
        e = exp_wr.pop_front();
        chk("write_addr", 32'(bus.bram_addr), 32'(e.a));
        chk("write_data", 32'(bus.bram_din), 32'(e.d));
      end
    end
    if (pixel_valid) begin
      if (exp_rd.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_pixel: got %0h, required no pixel_valid", pixel_out);
      end else begin
        r = exp_rd.pop_front();
        chk("pixel_out", 32'(pixel_out), 32'(r));
      end
    end
  end

  task automatic step(input int h, input int v, input logic [23:0] p);
    hcount   = 11'(h);
    vcount   = 10'(v);
    pixel_in = p;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(H_TOT - 1, V_TOT - 1, 24'h0);
  endtask

  // One raster; active pixels become expected writes (wr_base>=0) or reads (rd_base>=0).
  task automatic raster(input int f, input int wr_base, input int rd_base, input int max_act);
    int n = 0;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        logic [23:0] p;
        p = pix(f, h, v);
        if (h < H && v < V) begin
          if (n == max_act) return;
          n++;
          if (wr_base >= 0) begin
            exp_wr.push_back({6'(wr_base + v * H + h), p});
            shadow[wr_base + v * H + h] = p;
          end else if (rd_base >= 0) begin
            exp_rd.push_back(shadow[rd_base + rd_ptr]);
            rd_ptr = (rd_ptr + 1) % FP;
          end
        end
        hcount   = 11'(h);
        vcount   = 10'(v);
        pixel_in = p;
        if (f == 0 && v == 0 && h < 2) begin
          #1;
          chk("pack8", 32'(bus8.bram_din), 32'(pk8[h]));
          chk("pack16", 32'(bus16.bram_din), 32'(pk16[h]));
        end
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic probe(input int rd_base, input int n);
    rd_ptr = 0;
    for (int h = 1; h <= n; h++) begin
      exp_rd.push_back(shadow[rd_base + rd_ptr]);
      rd_ptr = rd_ptr + 1;
      step(h, 0, 24'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 24'h0;
      shadow[i] = 24'h0;
    end
    reset_n    = 1'b0;
    capture_sw = 1'b0;
    continuous = 1'b0;
    hcount     = 11'(H_TOT - 1);
    vcount     = 10'(V_TOT - 1);
    pixel_in   = 24'h123456;
    #7;
    chk("rst_we", 32'(bus.bram_we), 0);
    chk("rst_addr", 32'(bus.bram_addr), 0);
    chk("rst_din", 32'(bus.bram_din), 0);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_pixel_out", 32'(pixel_out), 0);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    chk("rst_busy", 32'(busy), 0);

    // Capture raised together with reset release: too early to be honoured.
    @(posedge clock); #1;
    reset_n    = 1'b1;
    capture_sw = 1'b1;
    idle(1);
    chk("early_rise_ignored", 32'(busy), 0);
    capture_sw = 1'b0;
    idle(1);

    // Single-shot capture, then two replayed frames (second one wraps to addr 0).
    capture_sw = 1'b1;
    idle(1);
    chk("armed_busy", 32'(busy), 1);
    raster(0, 0, -1, 99);
    chk("single_frame_ready", 32'(frame_ready), 1);
    chk("single_reading_busy", 32'(busy), 0);
    chk("single_writes_drained", exp_wr.size(), 0);
    rd_ptr = 0;
    raster(1, -1, 0, 99);
    raster(2, -1, 0, 99);
    chk("single_reads_drained", exp_rd.size(), 0);

    // Release from READING, then abort a capture after 10 writes.
    capture_sw = 1'b0;
    idle(1);
    chk("release_frame_ready", 32'(frame_ready), 0);
    chk("release_busy", 32'(busy), 0);
    capture_sw = 1'b1;
    idle(1);
    raster(3, 0, -1, 10);
    capture_sw = 1'b0;
    step(H_TOT - 1, 1, 24'h0);
    hcount = 11'd3;
    vcount = 10'd1;
    #1;
    chk("abort_we", 32'(bus.bram_we), 0);
    chk("abort_frame_ready", 32'(frame_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    @(posedge clock); #1;
    capture_sw = 1'b1;
    idle(1);
    raster(3, 0, -1, 99);
    chk("restart_frame_ready", 32'(frame_ready), 1);
    chk("restart_writes_drained", exp_wr.size(), 0);

    // Release on the very cycle of the 32nd write: must land in IDLE.
    capture_sw = 1'b0;
    idle(1);
    capture_sw = 1'b1;
    idle(1);
    raster(4, 0, -1, FP - 1);
    exp_wr.push_back({6'(FP - 1), pix(4, H - 1, V - 1)});
    shadow[FP - 1] = pix(4, H - 1, V - 1);
    capture_sw = 1'b0;
    step(H - 1, V - 1, pix(4, H - 1, V - 1));
    chk("simul_frame_ready", 32'(frame_ready), 0);
    chk("simul_busy", 32'(busy), 0);
    step(2, 2, 24'h0);
    step(3, 2, 24'h0);
    idle(1);

    // Continuous ping-pong over three frames; probes read the last completed slot.
    continuous = 1'b1;
    capture_sw = 1'b1;
    idle(1);
    raster(5, 0, -1, 99);
    chk("cont1_busy", 32'(busy), 1);
    chk("cont1_frame_ready", 32'(frame_ready), 1);
    probe(0, 7);
    raster(6, FP, -1, 99);
    chk("cont2_busy", 32'(busy), 1);
    probe(FP, 7);
    raster(7, 0, -1, 99);
    chk("cont3_busy", 32'(busy), 1);
    probe(0, 7);
    idle(1);
    chk("cont_writes_drained", exp_wr.size(), 0);
    chk("cont_reads_drained", exp_rd.size(), 0);

    // Asynchronous reset pulse in the middle of a write.
    raster(8, FP, -1, 5);
    hcount   = 11'd5;
    vcount   = 10'd0;
    pixel_in = pix(8, 5, 0);
    #1;
    chk("prereset_we", 32'(bus.bram_we), 1);
    reset_n = 1'b0;
    #1;
    chk("areset_we", 32'(bus.bram_we), 0);
    chk("areset_addr", 32'(bus.bram_addr), 0);
    chk("areset_din", 32'(bus.bram_din), 0);
    chk("areset_valid", 32'(pixel_valid), 0);
    chk("areset_frame_ready", 32'(frame_ready), 0);
    chk("areset_busy", 32'(busy), 0);
    #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    raster(9, -1, -1, 99);
    chk("postreset_busy", 32'(busy), 0);
    chk("postreset_frame_ready", 32'(frame_ready), 0);

    chk("final_writes_drained", exp_wr.size(), 0);
    chk("final_reads_drained", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
